// File: rtl/binary_mul_acc.sv
// -----------------------------------------------------------------------------
// binary_mul_acc
//
// Dot-product back end for a free-running pipelined unsigned multiplier whose
// single enable freezes every stage. Operand pairs go straight from upstream
// into the multiplier; this block follows each issue slot with a {valid,last}
// tag that moves in lockstep with the multiplier, adds up the products of each
// group, and hands out one sum per group over a valid/ready handshake. When the
// result is not taken it freezes the multiplier and refuses new operands, so
// nothing in flight is lost.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream presents an operand pair to the multiplier
//   in_last    in   pair closes its group (only meaningful with in_valid)
//   in_ready   out  pair is accepted on an edge with in_valid && in_ready
//   mul_en     out  multiplier enable (low while the result is stalled)
//   mul_p      in   multiplier product, 2*WIDTH bits
//   out_valid  out  group result available
//   out_ready  in   downstream takes the result
//   out_sum    out  group sum, ACC_W bits
//   out_count  out  number of elements in the group (wraps at 2^CNT_W)
//   out_ovf    out  the group sum did not fit in ACC_W bits
//
// Build option
//   BINARY_MUL_ACC_SAT_EN  when defined, the running sum clamps at
//                          2^ACC_W-1 after the first carry and stays there for
//                          the rest of the group; otherwise it wraps.
//                          out_ovf reports the carry in both builds.
// -----------------------------------------------------------------------------
module binary_mul_acc #(
  parameter int WIDTH   = 11,
  parameter int LATENCY = 12,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 mul_en,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  // Tag pipe. Index 0 is written on the accepting edge; the product of that
  // element shows up on mul_p LATENCY enabled edges later, which is exactly
  // when the tag reaches index LATENCY.
  logic [LATENCY:0]   r_vld_p;
  logic [LATENCY:0]   r_last_p;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_stall;
  logic               w_accept;
  logic               w_consume;
  logic               w_done;
  logic [ACC_W:0]     w_raw;
  logic               w_ovf_any;
  logic [ACC_W-1:0]   w_next_sum;

`ifdef BINARY_MUL_ACC_SAT_EN
  // Once the group has carried, the sum is pinned to full scale.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] v,
                                               input logic              ovf);
    return ovf ? {ACC_W{1'b1}} : v;
  endfunction
`endif

  assign w_stall   = r_out_valid && !out_ready;
  assign mul_en    = !w_stall;
  assign in_ready  = !w_stall && !rst;
  assign w_accept  = in_valid && in_ready;

  // A tag is only consumed on an enabled edge; a frozen multiplier keeps the
  // same product on mul_p until the stall clears.
  assign w_consume = r_vld_p[LATENCY] && mul_en;
  assign w_done    = w_consume && r_last_p[LATENCY];

  // One extra bit catches the carry out of ACC_W.
  assign w_raw     = {1'b0, r_acc} + {{(ACC_W + 1 - 2*WIDTH){1'b0}}, mul_p};
  assign w_ovf_any = r_ovf | w_raw[ACC_W];

`ifdef BINARY_MUL_ACC_SAT_EN
  assign w_next_sum = sat_acc(w_raw[ACC_W-1:0], w_ovf_any);
`else
  assign w_next_sum = w_raw[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p     <= '0;
      r_last_p    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      // ---- stage 0 .. LATENCY: tag pipe shifting with the multiplier ----
      if (mul_en) begin
        r_vld_p  <= {r_vld_p[LATENCY-1:0], w_accept};
        r_last_p <= {r_last_p[LATENCY-1:0], in_last};
      end

      // ---- accumulate stage: product meets its tag ----
      if (w_consume) begin
        if (r_last_p[LATENCY]) begin
          r_out_sum   <= w_next_sum;
          r_out_count <= r_cnt + CNT_W'(1);
          r_out_ovf   <= w_ovf_any;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc       <= w_next_sum;
          r_cnt       <= r_cnt + CNT_W'(1);
          r_ovf       <= w_ovf_any;
        end
      end

      // ---- output stage: a completion on the same edge as a take keeps
      //      out_valid high with the new data ----
      if (w_done)
        r_out_valid <= 1'b1;
      else if (out_ready)
        r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_binary_mul_acc.sv
module tb_binary_mul_acc;

  localparam int WIDTH   = 11;
  localparam int LATENCY = 12;
  localparam int ACC_W   = 24;
  localparam int CNT_W   = 16;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;
`ifdef BINARY_MUL_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               mul_en;
  logic [2*WIDTH-1:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf;

  logic [WIDTH-1:0]   a, b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_mul_acc #(.WIDTH(WIDTH), .LATENCY(LATENCY), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mul_en(mul_en), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  // Multiplier stand-in: samples a*b on an enabled edge, product visible on P
  // LATENCY enabled edges later; never reset, so it carries garbage.
  logic [2*WIDTH-1:0] mst [0:LATENCY];
  always @(posedge clk) begin
    if (mul_en) begin
      mst[0] <= a * b;
      for (int i = 1; i <= LATENCY; i++) mst[i] <= mst[i-1];
    end
  end
  assign mul_p = mst[LATENCY];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: group totals from accepted pairs, results queued in order.
  typedef struct { longint sum; int cnt; bit ovf; } res_t;
  res_t   expq[$];
  longint grp_tot = 0;
  int     grp_cnt = 0;

  always @(negedge clk) begin
    res_t r;
    // compare: every cycle a result is presented
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("model_sum",   64'(out_sum),   64'(expq[0].sum));
        chk("model_count", 64'(out_count), 64'(expq[0].cnt));
        chk("model_ovf",   64'(out_ovf),   64'(expq[0].ovf));
        if (out_ready) void'(expq.pop_front());
      end
    end
    // model update for the coming edge
    if (rst) begin
      grp_tot = 0;
      grp_cnt = 0;
      expq.delete();
    end else if (in_valid && in_ready) begin
      grp_tot += longint'(a) * longint'(b);
      grp_cnt += 1;
      if (in_last) begin
        r.ovf = (grp_tot > MAXV);
        r.sum = !r.ovf ? grp_tot : (SAT ? MAXV : (grp_tot & MAXV));
        r.cnt = grp_cnt % (1 << CNT_W);
        expq.push_back(r);
        grp_tot = 0;
        grp_cnt = 0;
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit last);
    bit got = 0;
    a = av; b = bv; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=0 required=1");
    end else begin
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Edges from now until out_valid is seen (sampled #1 after each edge).
  task automatic wait_valid(output int k);
    k = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = n; break; end
    end
    if (k == 0) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; out_ready = 1'b1;
    idle_inputs();

    // reset
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum",   64'(out_sum),   64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      chk("rst_out_ovf",   64'(out_ovf),   64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_mul_en",   64'(mul_en),   64'd1);
    repeat (20) begin @(posedge clk); #1; idle_inputs(); end

    // single group, latency
    send(11'd2047, 11'd2047, 1'b1);
    wait_valid(k);
    chk("single_latency", 64'(k),         64'd13);
    chk("single_sum",     64'(out_sum),   64'd4190209);
    chk("single_count",   64'(out_count), 64'd1);
    chk("single_ovf",     64'(out_ovf),   64'd0);
    @(posedge clk); #1;
    chk("single_drop", 64'(out_valid), 64'd0);

    // back-to-back groups
    send(11'd3, 11'd5, 1'b0);
    send(11'd7, 11'd11, 1'b0);
    send(11'd2047, 11'd1, 1'b0);
    send(11'd0, 11'd2047, 1'b1);
    send(11'd10, 11'd10, 1'b1);
    wait_valid(k);
    chk("b2b_sum0",   64'(out_sum),   64'd2139);
    chk("b2b_cnt0",   64'(out_count), 64'd4);
    @(posedge clk); #1;
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_sum1",   64'(out_sum),   64'd100);
    chk("b2b_cnt1",   64'(out_count), 64'd1);
    @(posedge clk); #1;
    chk("b2b_drop",   64'(out_valid), 64'd0);

    // backpressure
    out_ready = 1'b0;
    send(11'd3, 11'd5, 1'b0);
    send(11'd7, 11'd11, 1'b0);
    send(11'd2047, 11'd1, 1'b0);
    send(11'd0, 11'd2047, 1'b1);
    send(11'd10, 11'd10, 1'b1);
    wait_valid(k);
    chk("bp_first_sum", 64'(out_sum), 64'd2139);
    fork
      send(11'd6, 11'd7, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_valid",  64'(out_valid), 64'd1);
          chk("bp_hold_sum",    64'(out_sum),   64'd2139);
          chk("bp_in_ready",    64'(in_ready),  64'd0);
          chk("bp_mul_en",      64'(mul_en),    64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_sum",   64'(out_sum),   64'd100);
    chk("bp_next_count", 64'(out_count), 64'd1);
    wait_valid(k);
    chk("bp_held_pair_sum", 64'(out_sum), 64'd42);
    @(posedge clk); #1;

    // overflow at ACC_W=24
    for (int i = 0; i < 5; i++) send(11'd2047, 11'd2047, i == 4);
    wait_valid(k);
    chk("ovf_sum",   64'(out_sum),   SAT ? 64'd16777215 : 64'd4173829);
    chk("ovf_flag",  64'(out_ovf),   64'd1);
    chk("ovf_count", 64'(out_count), 64'd5);
    @(posedge clk); #1;

    // reset mid-group
    send(11'd100, 11'd200, 1'b0);
    send(11'd5, 11'd5, 1'b0);
    send(11'd9, 11'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(11'd4, 11'd4, 1'b1);
    wait_valid(k);
    chk("midrst_latency", 64'(k),         64'd13);
    chk("midrst_sum",     64'(out_sum),   64'd16);
    chk("midrst_count",   64'(out_count), 64'd1);
    chk("midrst_ovf",     64'(out_ovf),   64'd0);

    repeat (30) begin @(posedge clk); #1; end
    chk("pending_results", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
